// File: rtl/output_port_allocator_if.sv
// Request/credit side and pop/select side of one router output port.
// The allocator sits on the slave modport; the input buffers and downstream link sit on master.
interface output_port_allocator_if #(
   parameter int CRED_W = 3
) ();
   logic [4:0]        req_valid;
   logic [4:0]        req_tail;
   logic              credit_in;
   logic [4:0]        pop;
   logic [2:0]        grant;
   logic              out_valid;
   logic [CRED_W-1:0] credits;
   logic              credit_err;

   modport master (
      output req_valid, req_tail, credit_in,
      input  pop, grant, out_valid, credits, credit_err
   );

   modport slave (
      input  req_valid, req_tail, credit_in,
      output pop, grant, out_valid, credits, credit_err
   );
endinterface

// File: rtl/output_port_allocator.sv
// Wormhole output-port allocator: packet-granular round-robin among N,S,E,W,L inputs,
// grant held head-to-tail, flit transfer gated on downstream credits.
module output_port_allocator #(
   parameter int CREDITS = 4,
   parameter int CRED_W  = 3
) (
   input logic                  clk,
   input logic                  reset,
   output_port_allocator_if.slave bus
);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_t;

   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);
   localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);
   localparam logic [2:0]        GRANT_NONE = 3'd7;

   state_t            state_q, state_d;
   logic [2:0]        owner_q, owner_d;
   logic [2:0]        ptr_q, ptr_d;
   logic [CRED_W-1:0] cred_q, cred_d;
   logic              err_q, err_d;
   logic              xfer;
   logic [2:0]        winner;
   logic              found;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= 3'd4;
         cred_q  <= CRED_MAX;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cred_q  <= cred_d;
         err_q   <= err_d;
      end
   end

   // Round-robin scan starting just after the last served input; ptr itself comes last
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int unsigned k = 1; k <= 5; k++) begin
         int unsigned idx;
         idx = ({29'd0, ptr_q} + k) % 5;
         if (!found && bus.req_valid[idx]) begin
            winner = 3'(idx);
            found  = 1'b1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               owner_d = winner;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (xfer && bus.req_tail[owner_q]) begin
               ptr_d   = owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: pop/out_valid follow the owner's request in the same cycle
   always_comb begin
      xfer      = 1'b0;
      bus.grant = GRANT_NONE;
      bus.pop   = '0;
      if (state_q == LOCKED) begin
         bus.grant = owner_q;
         xfer      = bus.req_valid[owner_q] && (cred_q != '0);
         if (xfer)
            bus.pop = 5'b00001 << owner_q;
      end
      bus.out_valid = xfer;
   end

   // Credits: simultaneous consume and return cancel; a return at full count is an error
   always_comb begin
      cred_d = cred_q;
      err_d  = err_q;
      if (xfer && !bus.credit_in)
         cred_d = cred_q - CRED_ONE;
      else if (!xfer && bus.credit_in) begin
         if (cred_q == CRED_MAX)
            err_d = 1'b1;
         else
            cred_d = cred_q + CRED_ONE;
      end
   end

   assign bus.credits    = cred_q;
   assign bus.credit_err = err_q;

endmodule
